// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding and defaults for the fetch/decode/execute sequencer
package cpu_ctrl_pkg;

  localparam int WAIT_MAX_DEF = 8;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_WB,
    S_HALTED,
    S_FAULT
  } state_e;

  // FETCH and MEM are the only states that wait on the memory handshake
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/fde_step_sequencer_if.sv
// rtl/fde_step_sequencer_if.sv - memory request/handshake bundle between sequencer and memory
interface fde_step_sequencer_if;

  logic mem_rd;
  logic mem_wr;
  logic mem_ready;

  modport master (output mem_rd, output mem_wr, input mem_ready);
  modport slave  (input mem_rd, input mem_wr, output mem_ready);

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory-wait cycles and flags the timeout cycle
module mem_wait_timer #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the WAIT_MAX-th consecutive cycle without mem_ready
  assign expire = count && (cnt_q == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/fde_step_sequencer.sv
// rtl/fde_step_sequencer.sv - multi-cycle fetch/decode/execute control sequencer with run/step, memory timeout and retire counter
module fde_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt_req,
  input  logic                    dec_mem,
  input  logic                    dec_store,
  input  logic                    dec_wb,
  input  logic                    dec_halt,
  fde_step_sequencer_if.master    mem,
  output logic                    pc_en,
  output logic                    ir_en,
  output logic                    mdr_en,
  output logic                    wb_en,
  output logic                    busy,
  output logic                    halted,
  output logic                    fault,
  output logic [CNT_W-1:0]        instr_cnt
);

  state_e             state_q, state_d;
  logic               single_q, single_d;
  logic               store_q, store_d;
  logic               wbl_q, wbl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_expire;
  logic               in_wait;

  assign in_wait = is_wait_state(state_q);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .count  (in_wait && !mem.mem_ready),
    .expire (wait_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      single_q <= 1'b0;
      store_q  <= 1'b0;
      wbl_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      store_q  <= store_d;
      wbl_q    <= wbl_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    store_d  = store_q;
    wbl_d    = wbl_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end else if (run && !halt_req) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (mem.mem_ready)    state_d = S_DECODE;
        else if (wait_expire) state_d = S_FAULT;
      end
      S_DECODE: begin
        store_d = dec_store;
        wbl_d   = dec_wb;
        if (dec_halt)     state_d = S_HALTED;
        else if (dec_mem) state_d = S_MEM;
        else              state_d = S_EXEC;
      end
      S_MEM: begin
        if (mem.mem_ready)    state_d = S_WB;
        else if (wait_expire) state_d = S_FAULT;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (single_q || halt_req || !run) state_d = S_IDLE;
        else                              state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_rd = 1'b0;
    mem.mem_wr = 1'b0;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mdr_en     = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_rd = 1'b1;
        ir_en      = mem.mem_ready;
        pc_en      = mem.mem_ready;
      end
      S_MEM: begin
        mem.mem_wr = store_q;
        mem.mem_rd = !store_q;
        mdr_en     = mem.mem_ready && !store_q;
      end
      S_WB:    wb_en = wbl_q;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_FAULT);
  assign halted    = (state_q == S_HALTED);
  assign fault     = (state_q == S_FAULT);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_fde_step_sequencer.sv
// tb/tb_fde_step_sequencer.sv - self-checking bench for fde_step_sequencer
module tb_fde_step_sequencer;

  localparam int CW = 4;
  localparam int WM = 8;
  localparam int C_RD = 0, C_WR = 1, C_IR = 2, C_PC = 3, C_MDR = 4, C_WB = 5, C_BUSY = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic dec_mem, dec_store, dec_wb, dec_halt;
  logic pc_en, ir_en, mdr_en, wb_en, busy, halted, fault;
  logic [CW-1:0] instr_cnt;

  fde_step_sequencer_if mif ();

  fde_step_sequencer #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .dec_mem   (dec_mem),
    .dec_store (dec_store),
    .dec_wb    (dec_wb),
    .dec_halt  (dec_halt),
    .mem       (mif),
    .pc_en     (pc_en),
    .ir_en     (ir_en),
    .mdr_en    (mdr_en),
    .wb_en     (wb_en),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mem;
    bit store;
    bit wb;
    bit halt;
  } instr_t;

  typedef struct {
    bit mem;
    bit store;
    bit wb;
    int fd;
    int md;
    int e_cyc;
    int e_rd;
    int e_wr;
    int e_mdr;
    int e_wb;
  } vec_t;

  instr_t iq[$];
  int     dq[$];
  instr_t cur_i;
  int     n[7];
  int     b[7];
  int     checks = 0;
  int     errors = 0;
  bit     have = 0;
  int     cur_d = 0;
  int     waited = 0;

  // Memory model: each new request takes the next latency from dq
  always @(negedge clk) begin
    #1;
    if (reset) begin
      have = 0;
      mif.mem_ready = 1'b0;
      dq.delete();
    end else if (mif.mem_rd || mif.mem_wr) begin
      if (!have) begin
        cur_d = 0;
        if (dq.size() > 0) cur_d = dq.pop_front();
        have = 1;
        waited = 0;
      end
      if (waited == cur_d) begin
        mif.mem_ready = 1'b1;
        have = 0;
      end else begin
        mif.mem_ready = 1'b0;
        waited++;
      end
    end else begin
      mif.mem_ready = 1'b0;
    end
  end

  // Activity counters and decode presenter: next instruction appears after its fetch
  always @(negedge clk) begin
    #2;
    if (reset) begin
      dec_mem = 0; dec_store = 0; dec_wb = 0; dec_halt = 0;
      iq.delete();
    end else begin
      n[C_RD]   += int'(mif.mem_rd);
      n[C_WR]   += int'(mif.mem_wr);
      n[C_IR]   += int'(ir_en);
      n[C_PC]   += int'(pc_en);
      n[C_MDR]  += int'(mdr_en);
      n[C_WB]   += int'(wb_en);
      n[C_BUSY] += int'(busy);
      if (ir_en) begin
        cur_i = '{0, 0, 0, 0};
        if (iq.size() > 0) cur_i = iq.pop_front();
        dec_mem = cur_i.mem; dec_store = cur_i.store; dec_wb = cur_i.wb; dec_halt = cur_i.halt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int d(input int k);
    return n[k] - b[k];
  endfunction

  task automatic snap;
    for (int k = 0; k < 7; k++) b[k] = n[k];
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1; run = 0; step = 0; halt_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic pulse_step;
    @(negedge clk);
    step = 1;
    @(negedge clk);
    step = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (busy && k < budget);
    chk(name, busy, 0);
  endtask

  task automatic push_instr(input bit m, input bit s, input bit w, input bit h, input int fd, input int md);
    iq.push_back('{m, s, w, h});
    dq.push_back(fd);
    if (m && !h) dq.push_back(md);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pc_en"}, pc_en, 0);
    chk({tag, "_ir_en"}, ir_en, 0);
    chk({tag, "_mdr_en"}, mdr_en, 0);
    chk({tag, "_wb_en"}, wb_en, 0);
    chk({tag, "_mem_rd"}, mif.mem_rd, 0);
    chk({tag, "_mem_wr"}, mif.mem_wr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_instr_cnt"}, instr_cnt, 0);
  endtask

  vec_t vt[9];

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    int nins, cyc, rd, wr, mdr, wbc;
    instr_t t;
    int fd, md;

    for (int k = 0; k < 7; k++) begin n[k] = 0; b[k] = 0; end

    // {mem, store, wb, fetch_delay, mem_delay, cycles, rd, wr, mdr, wb}
    vt[0] = '{0, 0, 1, 0, 0,  4, 1, 0, 0, 1};
    vt[1] = '{0, 0, 0, 0, 0,  4, 1, 0, 0, 0};
    vt[2] = '{1, 0, 1, 0, 0,  4, 2, 0, 1, 1};
    vt[3] = '{1, 1, 0, 0, 0,  4, 1, 1, 0, 0};
    vt[4] = '{1, 0, 1, 2, 3,  9, 7, 0, 1, 1};
    vt[5] = '{1, 1, 0, 1, 7, 12, 2, 8, 0, 0};
    vt[6] = '{0, 0, 1, 7, 0, 11, 8, 0, 0, 1};
    vt[7] = '{0, 1, 0, 0, 0,  4, 1, 0, 0, 0};
    vt[8] = '{1, 0, 0, 0, 0,  4, 2, 0, 1, 0};

    do_reset;
    #3;
    chk_idle_outputs("reset");

    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      push_instr(vt[i].mem, vt[i].store, vt[i].wb, 0, vt[i].fd, vt[i].md);
      snap;
      pulse_step;
      wait_idle(64, $sformatf("v%0d_done", i));
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk($sformatf("v%0d_cycles", i), d(C_BUSY), vt[i].e_cyc);
      chk($sformatf("v%0d_mem_rd", i), d(C_RD), vt[i].e_rd);
      chk($sformatf("v%0d_mem_wr", i), d(C_WR), vt[i].e_wr);
      chk($sformatf("v%0d_mdr_en", i), d(C_MDR), vt[i].e_mdr);
      chk($sformatf("v%0d_wb_en", i), d(C_WB), vt[i].e_wb);
      chk($sformatf("v%0d_ir_en", i), d(C_IR), 1);
      chk($sformatf("v%0d_pc_en", i), d(C_PC), 1);
      chk($sformatf("v%0d_instr_cnt", i), instr_cnt, exp_cnt);
      chk($sformatf("v%0d_fault", i), fault, 0);
    end

    // Fetch timeout: 8 cycles of mem_rd, then sticky fault
    do_reset;
    push_instr(0, 0, 1, 0, 255, 0);
    snap;
    pulse_step;
    wait_idle(64, "to_done");
    chk("to_mem_rd_cycles", d(C_RD), WM);
    chk("to_busy_cycles", d(C_BUSY), WM);
    chk("to_ir_en", d(C_IR), 0);
    chk("to_fault", fault, 1);
    chk("to_mem_rd_after", mif.mem_rd, 0);
    pulse_step;
    repeat (5) @(negedge clk);
    #3;
    chk("to_fault_sticky", fault, 1);
    chk("to_no_restart", d(C_BUSY), WM);
    chk("to_no_enables", d(C_IR) + d(C_MDR) + d(C_WB) + d(C_WR), 0);
    do_reset;
    #3;
    chk_idle_outputs("to_reset");

    // Reset mid-handshake drops the request
    push_instr(0, 0, 1, 0, 255, 0);
    snap;
    pulse_step;
    repeat (2) @(negedge clk);
    do_reset;
    #3;
    chk("mid_rst_ir_en", d(C_IR), 0);
    chk_idle_outputs("mid_rst");

    // Free run, alternating load/store
    do_reset;
    for (int i = 0; i < 12; i++) push_instr(1, i[0], !i[0], 0, 0, 0);
    snap;
    @(negedge clk);
    run = 1;
    repeat (41) @(negedge clk);
    #3;
    chk("fr_instr_cnt_40", instr_cnt, 10);
    chk("fr_mdr_en", d(C_MDR), 5);
    chk("fr_mem_wr", d(C_WR), 5);
    chk("fr_busy_cycles", d(C_BUSY), 41);
    halt_req = 1;
    wait_idle(32, "fr_done");
    chk("fr_instr_cnt_end", instr_cnt, 11);
    chk("fr_mdr_end", d(C_MDR), 6);
    run = 0;
    halt_req = 0;

    // HALT on third instruction
    do_reset;
    push_instr(0, 0, 1, 0, 0, 0);
    push_instr(1, 0, 1, 0, 0, 0);
    push_instr(1, 1, 1, 1, 0, 0);
    snap;
    @(negedge clk);
    run = 1;
    wait_idle(64, "hl_done");
    chk("hl_halted", halted, 1);
    chk("hl_instr_cnt", instr_cnt, 2);
    chk("hl_busy_cycles", d(C_BUSY), 10);
    chk("hl_wb_en", d(C_WB), 2);
    chk("hl_mem_wr", d(C_WR), 0);
    pulse_step;
    repeat (4) @(negedge clk);
    #3;
    chk("hl_step_ignored", d(C_IR), 3);
    chk("hl_still_halted", halted, 1);
    run = 0;

    // halt_req mid-instruction, second instruction has no write-back
    do_reset;
    push_instr(0, 0, 1, 0, 0, 0);
    push_instr(0, 0, 0, 0, 0, 0);
    push_instr(0, 0, 1, 0, 0, 0);
    push_instr(0, 0, 1, 0, 0, 0);
    snap;
    @(negedge clk);
    run = 1;
    repeat (6) @(negedge clk);
    halt_req = 1;
    wait_idle(32, "hr_done");
    chk("hr_instr_cnt", instr_cnt, 2);
    chk("hr_wb_en", d(C_WB), 1);
    chk("hr_busy_cycles", d(C_BUSY), 8);
    repeat (3) @(negedge clk);
    #3;
    chk("hr_stays_idle", d(C_BUSY), 8);
    run = 0;
    halt_req = 0;

    // Counter wrap
    do_reset;
    for (int i = 0; i < (1 << CW); i++) begin
      push_instr(0, 0, 1, 0, 0, 0);
      pulse_step;
      wait_idle(32, "wr_done");
      if (i == (1 << CW) - 2) chk("wr_cnt_max", instr_cnt, (1 << CW) - 1);
    end
    chk("wr_cnt_wrapped", instr_cnt, 0);

    // Randomized free-run programs ending in HALT, checked against totals
    for (int it = 0; it < 10; it++) begin
      do_reset;
      nins = $urandom_range(1, 8);
      cyc = 0; rd = 0; wr = 0; mdr = 0; wbc = 0;
      for (int k = 0; k < nins; k++) begin
        t.mem = 1'($urandom_range(0, 1));
        t.store = 1'($urandom_range(0, 1));
        t.wb = 1'($urandom_range(0, 1));
        t.halt = (k == nins - 1);
        fd = $urandom_range(0, WM - 1);
        md = $urandom_range(0, WM - 1);
        push_instr(t.mem, t.store, t.wb, t.halt, fd, md);
        cyc += fd + 2;
        rd += fd + 1;
        if (!t.halt) begin
          cyc += 1;
          if (t.mem) begin
            cyc += md + 1;
            if (t.store) wr += md + 1;
            else begin rd += md + 1; mdr++; end
          end else begin
            cyc += 1;
          end
          if (t.wb) wbc++;
        end
      end
      snap;
      @(negedge clk);
      run = 1;
      wait_idle(600, $sformatf("rnd%0d_done", it));
      run = 0;
      chk($sformatf("rnd%0d_cycles", it), d(C_BUSY), cyc);
      chk($sformatf("rnd%0d_mem_rd", it), d(C_RD), rd);
      chk($sformatf("rnd%0d_mem_wr", it), d(C_WR), wr);
      chk($sformatf("rnd%0d_mdr_en", it), d(C_MDR), mdr);
      chk($sformatf("rnd%0d_wb_en", it), d(C_WB), wbc);
      chk($sformatf("rnd%0d_pc_en", it), d(C_PC), nins);
      chk($sformatf("rnd%0d_instr_cnt", it), instr_cnt, (nins - 1) % (1 << CW));
      chk($sformatf("rnd%0d_halted", it), halted, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fde_step_sequencer.md
Name: fde_step_sequencer

Overview:
- Multi-cycle control sequencer for the CPU datapath.
- Generates the clock-enable strobes that drive the bank of enable-gated D flip-flops (PC, IR, MDR, ACC/register write) so each stage register loads exactly once per instruction.
- Runs free or single-step, handshakes with instruction/data memory, and counts retired instructions.
- Sits between the top-level run/step controls and the datapath register enables.

Parameters:
- WAIT_MAX, 8: max cycles spent waiting for mem_ready in a memory state before declaring fault (1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = free-run mode
- step  in  1  single-cycle pulse; execute exactly one instruction from IDLE
- halt_req  in  1  level; stop at next instruction boundary
- mem_ready  in  1  memory handshake: read data valid / write accepted this cycle
- dec_mem  in  1  decoded instruction needs a data-memory access (valid in DECODE)
- dec_store  in  1  memory access is a write (valid in DECODE)
- dec_wb  in  1  instruction writes the register/ACC (valid in DECODE)
- dec_halt  in  1  instruction is HALT (valid in DECODE)
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- pc_en  out  1  PC register enable
- ir_en  out  1  IR register enable
- mdr_en  out  1  MDR register enable
- wb_en  out  1  register/ACC write enable
- busy  out  1  1 whenever state is not IDLE, HALTED or FAULT
- halted  out  1  HALTED state flag
- fault  out  1  memory-timeout flag
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, MEM, EXEC, WB, HALTED, FAULT. Encoding is free; state is one register.
- Reset (synchronous, applied at any state, including mid-handshake):
  - State returns to IDLE; instr_cnt=0; wait counter=0; mode flag=0.
  - All outputs read 0.
  - Any in-flight memory request is dropped with no enable pulse.
- IDLE:
  - step=1 → FETCH, mode=single. step has priority over run.
  - Otherwise run=1 and halt_req=0 → FETCH, mode=free.
  - Otherwise stay.
- FETCH:
  - mem_rd=1.
  - On mem_ready=1: ir_en=1 and pc_en=1 in that same cycle, then → DECODE.
  - If mem_ready is not seen within WAIT_MAX cycles of entering the state → FAULT.
- DECODE: exactly one cycle, all enables 0. Next state in priority order:
  - dec_halt → HALTED.
  - dec_mem → MEM.
  - Otherwise → EXEC.
  - dec_store and dec_wb are latched internally here.
- MEM:
  - mem_wr=latched store, mem_rd=!latched store.
  - On mem_ready: mdr_en=1 for loads only (0 for stores), then → WB.
  - Timeout → FAULT, same rule as FETCH.
- EXEC: one cycle, all enables 0, → WB.
- WB:
  - One cycle. wb_en = latched dec_wb. instr_cnt increments (wraps at 2^CNT_W−1 → 0).
  - Next: mode=single → IDLE; else halt_req=1 or run=0 → IDLE; else → FETCH.
- HALTED: halted=1, sticky until reset. HALT does not increment instr_cnt.
- FAULT: fault=1, sticky until reset. No enables or memory requests are asserted.
- Wait counter: cleared on entry to FETCH/MEM; increments each cycle mem_ready=0. Fault fires on the cycle the counter reaches WAIT_MAX with mem_ready still 0. If mem_ready=1 on that same cycle, the handshake wins.
- Enables and mem_rd/mem_wr are combinational from state, mem_ready and latched decode bits.
- Cycle counts with mem_ready=1 immediately:
  - ALU instruction = 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction = 4 cycles (FETCH, DECODE, MEM, WB).
- Inputs run, step and halt_req are ignored outside the states that sample them. A step pulse while busy is dropped.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state enum/localparams (S_IDLE..S_FAULT), and the WAIT_MAX and CNT_W defaults.
- One natural sub-module: mem_wait_timer (load/clear, count, expire output), reused by FETCH and MEM.
- The FSM and enable decode stay in this module.

Test Plan:
- Reset, then step=1 for one cycle with mem_ready tied 1 and an ALU decode (dec_wb=1):
  - FETCH→DECODE→EXEC→WB→IDLE.
  - ir_en and pc_en high together once; wb_en high once; instr_cnt=1; busy=0 afterwards.
- run=1, alternating load (dec_mem=1, dec_store=0) and store instructions, mem_ready=1:
  - 4 cycles each.
  - mdr_en pulses only on loads; mem_wr only in store MEM cycles.
  - instr_cnt=10 after 40 cycles.
- FETCH with mem_ready held 0, WAIT_MAX=8:
  - mem_rd held high 8 cycles, then fault=1 with all enables 0.
  - State stays FAULT until reset; reset returns to IDLE with instr_cnt=0.
- mem_ready=1 on exactly the 8th wait cycle: handshake completes, ir_en=1, no fault.
- run=1, dec_halt=1 on the third instruction: halted=1 after its DECODE; instr_cnt=2; step is ignored thereafter.
- halt_req asserted mid-instruction in free-run: current instruction completes (wb_en as decoded), then IDLE. Also set instr_cnt to 0xFFFF before one WB: it wraps to 0.
